// File: rtl/tim_arb_pkg.sv
// Shared definitions for the round-robin select arbiter: select codes,
// requester count, FSM state type and the index-to-select-code mapping.
package tim_arb_pkg;

  localparam int NUM_REQ = 3;

  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_C    = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Requester index to the select code understood by the downstream mux.
  // Index 3 does not name a requester, so it maps to the idle code.
  function automatic logic [1:0] idx_to_sel(input logic [1:0] idx);
    logic [1:0] sel;
    case (idx)
      2'd0:    sel = SEL_A;
      2'd1:    sel = SEL_B;
      2'd2:    sel = SEL_C;
      default: sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/tim_rr_pick.sv
// Combinational rotating-priority picker. The search starts at the
// requester after 'last' (mod 3); the first asserted request wins.
import tim_arb_pkg::*;

module tim_rr_pick (
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [2:0] onehot,
  output logic [1:0] idx,
  output logic       any
);

  logic [1:0] first;
  logic [1:0] second;
  logic [1:0] third;

  // Search order derived from the previous winner; an out-of-range 'last'
  // behaves like last=2 so requester 0 leads.
  always_comb begin
    first  = 2'd0;
    second = 2'd1;
    third  = 2'd2;
    case (last)
      2'd0: begin first = 2'd1; second = 2'd2; third = 2'd0; end
      2'd1: begin first = 2'd2; second = 2'd0; third = 2'd1; end
      default: begin first = 2'd0; second = 2'd1; third = 2'd2; end
    endcase
  end

  // Take the first asserted request in search order.
  always_comb begin
    onehot = 3'b000;
    idx    = 2'd0;
    any    = 1'b0;
    if (req[first]) begin
      idx           = first;
      onehot[first] = 1'b1;
      any           = 1'b1;
    end else if (req[second]) begin
      idx            = second;
      onehot[second] = 1'b1;
      any            = 1'b1;
    end else if (req[third]) begin
      idx           = third;
      onehot[third] = 1'b1;
      any           = 1'b1;
    end
  end

endmodule

// File: rtl/tim_rr_sel_arbiter.sv
// Round-robin arbiter over three valid/ready requesters feeding a one-entry
// output register that carries the winner's data and its 2-bit select code.
//
// Handshake: a transfer happens on a channel in any cycle where its valid and
// ready are both high at the rising clock edge. Valid never waits on ready;
// ready may depend on valid. req_ready is one-hot (or zero) and only ever
// asserted for the picked requester while the output register can load
// (it is empty, or it is being drained this same cycle via out_ready).
import tim_arb_pkg::*;

module tim_rr_sel_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           req_valid,
  input  logic [3*WIDTH-1:0]   req_data,
  output logic [2:0]           req_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           out_sel,
  output logic [WIDTH-1:0]     out_data
);

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       last_grant;
  logic [2:0]       pick_onehot;
  logic [1:0]       pick_idx;
  logic             pick_any;
  logic             can_load;
  logic             xfer;
  logic [WIDTH-1:0] win_data;

  tim_rr_pick u_pick (
    .req    (req_valid),
    .last   (last_grant),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Accept only when the register is free or being emptied this cycle;
  // reset forces ready low so nothing is accepted while the block is held.
  always_comb begin
    can_load  = (state == ST_EMPTY) | out_ready;
    req_ready = 3'b000;
    if (can_load && pick_any && !rst) begin
      req_ready = pick_onehot;
    end
    xfer = |(req_valid & req_ready);
  end

  // Select the winning requester's data slice.
  always_comb begin
    win_data = '0;
    case (pick_idx)
      2'd0:    win_data = req_data[0       +: WIDTH];
      2'd1:    win_data = req_data[WIDTH   +: WIDTH];
      2'd2:    win_data = req_data[2*WIDTH +: WIDTH];
      default: win_data = '0;
    endcase
  end

  // Next-state logic: load moves to FULL, a drain with nothing new empties.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (xfer) state_nxt = ST_FULL;
      ST_FULL:  if (out_ready && !xfer) state_nxt = ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Output register and rotation pointer; last_grant moves only on transfers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data   <= '0;
      out_sel    <= SEL_NONE;
      last_grant <= 2'd2;
    end else if (xfer) begin
      out_data   <= win_data;
      out_sel    <= idx_to_sel(pick_idx);
      last_grant <= pick_idx;
    end else if (state == ST_FULL && out_ready) begin
      out_data   <= '0;
      out_sel    <= SEL_NONE;
    end
  end

  assign out_valid = (state == ST_FULL);

endmodule

// File: tb/tb_tim_rr_sel_arbiter.sv
// Bench for tim_rr_sel_arbiter: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a queue-based model.
module tb_tim_rr_sel_arbiter;

  localparam int WIDTH = 8;

  logic               clk;
  logic               rst;
  logic [2:0]         req_valid;
  logic [3*WIDTH-1:0] req_data;
  logic [2:0]         req_ready;
  logic               out_valid;
  logic               out_ready;
  logic [1:0]         out_sel;
  logic [WIDTH-1:0]   out_data;

  int checks = 0;
  int errors = 0;

  tim_rr_sel_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel),
    .out_data  (out_data)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [2:0] v, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic rdy);
    req_valid = v;
    req_data  = {c, b, a};
    out_ready = rdy;
  endtask

  // ---------------- behavioural model + scoreboard ----------------
  // The model holds the item in the output register as the head of exp_q
  // ({sel, data}); rotation starts after the last winner.
  logic [WIDTH+1:0] exp_q[$];
  int               m_last = 2;

  always @(negedge clk) begin
    logic [2:0]       exp_rdy;
    logic [1:0]       exp_sel;
    logic [WIDTH-1:0] exp_data;
    logic             exp_valid;
    int               win;
    bit               can_load;
    if (rst) begin
      exp_q.delete();
      m_last = 2;
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out_sel",   {30'b0, out_sel},   32'd3);
      chk("rst_out_data",  {24'b0, out_data},  32'd0);
      chk("rst_req_ready", {29'b0, req_ready}, 32'd0);
    end else begin
      exp_valid = (exp_q.size() != 0);
      exp_sel   = exp_valid ? exp_q[0][WIDTH+1:WIDTH] : 2'b11;
      exp_data  = exp_valid ? exp_q[0][WIDTH-1:0] : '0;
      can_load  = !exp_valid || out_ready;
      win = -1;
      for (int k = 1; k <= 3; k++) begin
        int i;
        i = (m_last + k) % 3;
        if (win < 0 && req_valid[i]) win = i;
      end
      exp_rdy = 3'b000;
      if (can_load && win >= 0) exp_rdy[win] = 1'b1;
      chk("m_out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
      chk("m_out_sel",   {30'b0, out_sel},   {30'b0, exp_sel});
      chk("m_out_data",  {24'b0, out_data},  {24'b0, exp_data});
      chk("m_req_ready", {29'b0, req_ready}, {29'b0, exp_rdy});
      // advance the model to what the next edge must produce
      if (exp_valid && out_ready) void'(exp_q.pop_front());
      if (exp_rdy != 3'b000) begin
        logic [1:0] s;
        s = 2'(win);
        exp_q.push_back({s, req_data[win*WIDTH +: WIDTH]});
        m_last = win;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    set_in(3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Round robin, all requesting.
    set_in(3'b111, 8'h11, 8'h22, 8'h33, 1'b1);
    #1;
    chk("rr_rdy0", {29'b0, req_ready}, 32'h1);
    chk("rr_idle_valid", {31'b0, out_valid}, 32'd0);
    tick(); chk("rr_sel0", {30'b0, out_sel}, 32'h0); chk("rr_dat0", {24'b0, out_data}, 32'h11);
    chk("rr_rdy1", {29'b0, req_ready}, 32'h2);
    tick(); chk("rr_sel1", {30'b0, out_sel}, 32'h1); chk("rr_dat1", {24'b0, out_data}, 32'h22);
    chk("rr_rdy2", {29'b0, req_ready}, 32'h4);
    tick(); chk("rr_sel2", {30'b0, out_sel}, 32'h2); chk("rr_dat2", {24'b0, out_data}, 32'h33);
    tick(); chk("rr_sel3", {30'b0, out_sel}, 32'h0); chk("rr_dat3", {24'b0, out_data}, 32'h11);

    // Async reset while FULL holding A5.
    set_in(3'b000, 8'h00, 8'h00, 8'h00, 1'b1);
    tick();
    set_in(3'b001, 8'hA5, 8'h00, 8'h00, 1'b1);
    tick();
    set_in(3'b000, 8'hA5, 8'h00, 8'h00, 1'b0);
    #1 chk("pre_rst_data", {24'b0, out_data}, 32'hA5);
    rst = 1'b1;
    #1;
    chk("async_valid", {31'b0, out_valid}, 32'd0);
    chk("async_sel",   {30'b0, out_sel},   32'd3);
    chk("async_data",  {24'b0, out_data},  32'd0);
    tick(); tick();
    rst = 1'b0;
    set_in(3'b111, 8'h11, 8'h22, 8'h33, 1'b1);
    #1 chk("post_rst_rdy", {29'b0, req_ready}, 32'h1);
    tick(); chk("post_rst_sel", {30'b0, out_sel}, 32'h0);

    // Backpressure with b held.
    set_in(3'b010, 8'h11, 8'h22, 8'h33, 1'b1);
    tick();
    set_in(3'b101, 8'h11, 8'h22, 8'h33, 1'b0);
    for (int n = 0; n < 5; n++) begin
      #1;
      chk("bp_rdy",  {29'b0, req_ready}, 32'h0);
      chk("bp_sel",  {30'b0, out_sel},   32'h1);
      chk("bp_data", {24'b0, out_data},  32'h22);
      tick();
    end
    out_ready = 1'b1;
    #1 chk("bp_release_rdy", {29'b0, req_ready}, 32'h4);
    tick(); chk("bp_next_sel", {30'b0, out_sel}, 32'h2);

    // Single requester b, granted every cycle.
    set_in(3'b010, 8'h00, 8'h7E, 8'h00, 1'b1);
    for (int n = 0; n < 6; n++) begin
      #1 chk("single_rdy", {29'b0, req_ready}, 32'h2);
      tick();
      chk("single_valid", {31'b0, out_valid}, 32'd1);
      chk("single_sel",   {30'b0, out_sel},   32'h1);
      chk("single_data",  {24'b0, out_data},  32'h7E);
    end

    // Drain to empty and stay there.
    set_in(3'b000, 8'h00, 8'h00, 8'h00, 1'b1);
    tick();
    chk("drain_valid", {31'b0, out_valid}, 32'd0);
    chk("drain_sel",   {30'b0, out_sel},   32'd3);
    chk("drain_data",  {24'b0, out_data},  32'd0);
    tick();
    chk("empty_stay", {31'b0, out_valid}, 32'd0);

    // Skip idle requesters.
    set_in(3'b001, 8'h44, 8'h55, 8'h66, 1'b1);
    tick();
    #1 chk("skip_rdy_a", {29'b0, req_ready}, 32'h1);
    tick(); chk("skip_sel_a", {30'b0, out_sel}, 32'h0);
    req_valid = 3'b110;
    #1 chk("skip_rdy_b", {29'b0, req_ready}, 32'h2);
    tick(); chk("skip_sel_b", {30'b0, out_sel}, 32'h1);

    // Randomized traffic with occasional reset pulses.
    for (int n = 0; n < 3000; n++) begin
      req_valid = 3'($urandom_range(0, 7));
      req_data  = {8'($urandom), 8'($urandom), 8'($urandom)};
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      tick();
      rst = 1'b0;
    end

    set_in(3'b000, 8'h00, 8'h00, 8'h00, 1'b1);
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tim_rr_sel_arbiter.md
Name: tim_rr_sel_arbiter

Overview:
- Round-robin arbiter that generates the 2-bit select code consumed by the downstream priority mux, which routes a, b or c and drives 8'h00 on the default code.
- Three requesters present valid/data and receive a ready strobe.
- The winner's data and its select code are captured into a one-entry output register with a valid/ready handshake.
- Sits upstream of the mux and lint-clean: complete assignments in every comb branch.

Parameters:
- WIDTH, 8, data width of each requester and of out_data.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  3  per-requester valid; bit 0=a, 1=b, 2=c.
- req_data  input  3*WIDTH  packed requester data; slice i belongs to requester i.
- req_ready  output  3  one-hot accept; transfer on req_valid[i] & req_ready[i].
- out_valid  output  1  output register holds a granted item.
- out_ready  input  1  downstream accepts the item when out_valid & out_ready.
- out_sel  output  2  00=a, 01=b, 10=c, 11=none (idle/default code).
- out_data  output  WIDTH  captured data of the granted requester.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - out_valid=0, out_sel=2'b11, out_data=0, req_ready=3'b000.
  - Internal last_grant=2, so requester 0 has top priority first.
  - State=EMPTY.
- FSM, two states:
  - EMPTY: output register empty.
  - FULL: out_valid=1.
- Load condition `can_load = (state==EMPTY) | out_ready`.
- Pick: rotating priority starting at last_grant+1 (mod 3), first set bit of req_valid wins.
- req_ready:
  - One-hot of the pick when can_load and any req_valid; else 3'b000.
  - Never more than one bit set.
  - Never set for a requester whose req_valid is low.
- On a transfer (any req_valid & req_ready):
  - Next edge: out_data <= winner slice, out_sel <= winner code, out_valid <= 1, last_grant <= winner, state -> FULL.
  - Latency 1 cycle from accept to out_valid.
- FULL & out_ready & no request:
  - Next edge: out_valid <= 0, out_sel <= 2'b11, out_data <= 0, state -> EMPTY.
- FULL & out_ready & request (simultaneous drain+load):
  - Stay FULL with the new item.
  - Sustained throughput 1 item/cycle.
- FULL & !out_ready:
  - out_sel, out_data, out_valid and last_grant hold stable.
  - req_ready=0.
- EMPTY & no request: outputs stay at reset values. No bubble insertion beyond that.
- last_grant updates only on a transfer, never on idle cycles.
- All three requesting continuously with out_ready=1: grant order 0,1,2,0,1,2…
- Only one requester active: it is granted every cycle; no wasted slots.
- Reset mid-operation:
  - The held item is discarded.
  - Outputs return to reset values immediately (async).
  - Arbitration restarts at requester 0.
- out_sel is never 2'b11 while out_valid=1, and is always 2'b11 while out_valid=0.
- All combinational blocks assign every output in every branch (default assignments first); no latches.

Decomposition:
- Package tim_arb_pkg:
  - SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_NONE=2'b11.
  - NUM_REQ=3.
  - State enum {ST_EMPTY, ST_FULL}.
  - Function index-to-select code.
- One sub-module: tim_rr_pick, purely combinational.
  - Inputs: req (3), last (2).
  - Outputs: onehot (3), idx (2), any (1).
- Top holds the FSM, the output register and last_grant.

Test Plan:
- Reset check: assert rst mid-FULL with out_data=8'hA5 -> same cycle out_valid=0, out_sel=2'b11, out_data=8'h00; after release, first grant goes to requester 0.
- Round-robin: all req_valid=3'b111, data a=8'h11, b=8'h22, c=8'h33, out_ready=1 -> out_sel sequence 00,01,10,00 and out_data 11,22,33,11 on consecutive cycles, one cycle after each req_ready.
- Backpressure: FULL with out_sel=01, out_data=8'h22, out_ready=0 for 5 cycles while req_valid=3'b101 -> req_ready=000, outputs stable; on out_ready=1 req_ready=100 (c wins after b).
- Single requester: only req_valid[1] high with data 8'h7E, out_ready=1 -> req_ready=010 every cycle, out_sel=01 continuously, no idle gaps.
- Drain to empty: FULL, requests drop, out_ready=1 -> next cycle out_valid=0, out_sel=11, out_data=00; state stays EMPTY with no requests.
- Skip idle requester: last_grant=0, req_valid=3'b001 -> requester 0 granted again (rotation skips 1 and 2); then req_valid=3'b110 -> requester 1 granted.
